// File: rtl/traffic_conflict_monitor_if.sv
// Lamp-code bus between the traffic light FSM (master) and the conflict monitor (slave).
// The master drives the requested codes and clear; the slave returns lamp drive and fault status.
interface traffic_conflict_monitor_if;
    logic [2:0] ns_in;
    logic [2:0] ew_in;
    logic       clr_fault;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output ns_in,
        output ew_in,
        output clr_fault,
        input  ns_lamp,
        input  ew_lamp,
        input  fault,
        input  fault_code
    );

    modport slave (
        input  ns_in,
        input  ew_in,
        input  clr_fault,
        output ns_lamp,
        output ew_lamp,
        output fault,
        output fault_code
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light FSM and the lamp drivers: registers lamp codes,
// detects conflicting/invalid codes and short yellows, and forces flashing red until cleared.
module traffic_conflict_monitor #(
    parameter int PERSIST     = 2,
    parameter int MIN_YELLOW  = 3,
    parameter int FLASH_HALF  = 4,
    parameter int ALLRED_HOLD = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    traffic_conflict_monitor_if.slave    bus
);

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_CONFLICT = 2'b01;
    localparam logic [1:0] CODE_INVALID  = 2'b10;
    localparam logic [1:0] CODE_YELLOW   = 2'b11;

    localparam int PW = (PERSIST > 1) ? $clog2(PERSIST) : 1;
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);
    localparam int HW = (ALLRED_HOLD > 1) ? $clog2(ALLRED_HOLD) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(PERSIST - 1);
    localparam logic [YW-1:0] Y_MIN   = YW'(MIN_YELLOW);
    localparam logic [FW-1:0] FC_HALF = FW'(FLASH_HALF);
    localparam logic [FW-1:0] FC_LAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(ALLRED_HOLD - 1);

    typedef enum logic [1:0] {
        ST_MON     = 2'd0,
        ST_FAULT   = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    state_e          state_q,      state_d;
    logic [2:0]      ns_lamp_q,    ns_lamp_d;
    logic [2:0]      ew_lamp_q,    ew_lamp_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic [2:0]      ns_prev_q,    ns_prev_d;
    logic [2:0]      ew_prev_q,    ew_prev_d;
    logic [YW-1:0]   ns_ycnt_q,    ns_ycnt_d;
    logic [YW-1:0]   ew_ycnt_q,    ew_ycnt_d;
    logic [PW-1:0]   pcnt_q,       pcnt_d;
    logic [FW-1:0]   fc_q,         fc_d;
    logic [HW-1:0]   hcnt_q,       hcnt_d;

    logic ns_ok, ew_ok, invalid, conflict, bad, all_red;
    logic ns_yviol, ew_yviol, yviol;

    function automatic logic is_onehot(input logic [2:0] c);
        return (c == LAMP_R) || (c == LAMP_Y) || (c == LAMP_G);
    endfunction

    // Consecutive-yellow count, saturating at the minimum needed to leave yellow legally.
    function automatic logic [YW-1:0] ycnt_next(input logic [2:0] cur, input logic [YW-1:0] cnt);
        if (cur != LAMP_Y) begin
            return '0;
        end
        return (cnt == Y_MIN) ? cnt : cnt + YW'(1);
    endfunction

    function automatic logic yellow_viol(input logic [2:0] prev, input logic [2:0] cur,
                                         input logic [YW-1:0] cnt);
        return (cur == LAMP_R) &&
               ((prev == LAMP_G) || ((prev == LAMP_Y) && (cnt < Y_MIN)));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_MON;
            ns_lamp_q    <= LAMP_R;
            ew_lamp_q    <= LAMP_R;
            fault_code_q <= CODE_NONE;
            ns_prev_q    <= LAMP_R;
            ew_prev_q    <= LAMP_R;
            ns_ycnt_q    <= '0;
            ew_ycnt_q    <= '0;
            pcnt_q       <= '0;
            fc_q         <= '0;
            hcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            ns_lamp_q    <= ns_lamp_d;
            ew_lamp_q    <= ew_lamp_d;
            fault_code_q <= fault_code_d;
            ns_prev_q    <= ns_prev_d;
            ew_prev_q    <= ew_prev_d;
            ns_ycnt_q    <= ns_ycnt_d;
            ew_ycnt_q    <= ew_ycnt_d;
            pcnt_q       <= pcnt_d;
            fc_q         <= fc_d;
            hcnt_q       <= hcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ns_lamp_d    = ns_lamp_q;
        ew_lamp_d    = ew_lamp_q;
        fault_code_d = fault_code_q;
        ns_prev_d    = ns_prev_q;
        ew_prev_d    = ew_prev_q;
        ns_ycnt_d    = ns_ycnt_q;
        ew_ycnt_d    = ew_ycnt_q;
        pcnt_d       = pcnt_q;
        fc_d         = fc_q;
        hcnt_d       = hcnt_q;

        ns_ok    = is_onehot(bus.ns_in);
        ew_ok    = is_onehot(bus.ew_in);
        invalid  = !(ns_ok && ew_ok);
        conflict = ns_ok && ew_ok && (bus.ns_in != LAMP_R) && (bus.ew_in != LAMP_R);
        bad      = invalid || conflict;
        all_red  = (bus.ns_in == LAMP_R) && (bus.ew_in == LAMP_R);
        // Previous codes only ever hold one-hot values, so a red current code implies a valid pair.
        ns_yviol = yellow_viol(ns_prev_q, bus.ns_in, ns_ycnt_q);
        ew_yviol = yellow_viol(ew_prev_q, bus.ew_in, ew_ycnt_q);
        yviol    = ns_yviol || ew_yviol;

        unique case (state_q)
            ST_MON: begin
                ns_lamp_d = bad ? LAMP_R : bus.ns_in;
                ew_lamp_d = bad ? LAMP_R : bus.ew_in;
                pcnt_d    = bad ? ((pcnt_q == P_LAST) ? pcnt_q : pcnt_q + PW'(1)) : '0;
                // An invalid code leaves history untouched so a glitch cannot hide a transition.
                if (ns_ok) begin
                    ns_prev_d = bus.ns_in;
                    ns_ycnt_d = ycnt_next(bus.ns_in, ns_ycnt_q);
                end
                if (ew_ok) begin
                    ew_prev_d = bus.ew_in;
                    ew_ycnt_d = ycnt_next(bus.ew_in, ew_ycnt_q);
                end
                if ((bad && (pcnt_q == P_LAST)) || yviol) begin
                    state_d   = ST_FAULT;
                    fc_d      = '0;
                    pcnt_d    = '0;
                    ns_lamp_d = LAMP_R;
                    ew_lamp_d = LAMP_R;
                    if (conflict) begin
                        fault_code_d = CODE_CONFLICT;
                    end else if (invalid) begin
                        fault_code_d = CODE_INVALID;
                    end else begin
                        fault_code_d = CODE_YELLOW;
                    end
                end
            end

            ST_FAULT: begin
                fc_d      = (fc_q == FC_LAST) ? '0 : fc_q + FW'(1);
                ns_lamp_d = (fc_d < FC_HALF) ? LAMP_R : LAMP_OFF;
                ew_lamp_d = ns_lamp_d;
                if (bus.clr_fault && all_red) begin
                    state_d   = ST_RECOVER;
                    hcnt_d    = '0;
                    ns_lamp_d = LAMP_R;
                    ew_lamp_d = LAMP_R;
                end
            end

            ST_RECOVER: begin
                ns_lamp_d = LAMP_R;
                ew_lamp_d = LAMP_R;
                if (!all_red) begin
                    hcnt_d = '0;
                end else if (hcnt_q == H_LAST) begin
                    state_d   = ST_MON;
                    hcnt_d    = '0;
                    ns_prev_d = LAMP_R;
                    ew_prev_d = LAMP_R;
                    ns_ycnt_d = '0;
                    ew_ycnt_d = '0;
                    pcnt_d    = '0;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end

            default: begin
                state_d   = ST_FAULT;
                fc_d      = '0;
                ns_lamp_d = LAMP_R;
                ew_lamp_d = LAMP_R;
            end
        endcase
    end

    assign bus.ns_lamp    = ns_lamp_q;
    assign bus.ew_lamp    = ew_lamp_q;
    assign bus.fault      = (state_q != ST_MON);
    assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed-vector bench for traffic_conflict_monitor with a queue-based scoreboard:
// each driven cycle queues the expected post-edge outputs, a monitor pops and compares them.
module tb_traffic_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       f;
        logic [1:0] code;
    } exp_t;

    logic  clk;
    logic  rst_n;
    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks;
    int    n_fail;

    traffic_conflict_monitor_if bus ();

    traffic_conflict_monitor #(
        .PERSIST    (2),
        .MIN_YELLOW (3),
        .FLASH_HALF (4),
        .ALLRED_HOLD(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string nm, input logic rn, input logic [2:0] ns, input logic [2:0] ew,
                        input logic clr, input logic [2:0] ens, input logic [2:0] eew,
                        input logic ef, input logic [1:0] ec);
        exp_t e;
        @(negedge clk);
        rst_n         = rn;
        bus.ns_in     = ns;
        bus.ew_in     = ew;
        bus.clr_fault = clr;
        e.ns   = ens;
        e.ew   = eew;
        e.f    = ef;
        e.code = ec;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are sampled just after each rising edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (bus.ns_lamp !== e.ns || bus.ew_lamp !== e.ew ||
                    bus.fault !== e.f || bus.fault_code !== e.code) begin
                    n_fail++;
                    $display("FAIL %s: got ns=%b ew=%b fault=%b code=%b, want ns=%b ew=%b fault=%b code=%b",
                             nm, bus.ns_lamp, bus.ew_lamp, bus.fault, bus.fault_code,
                             e.ns, e.ew, e.f, e.code);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.ns_in     = R;
        bus.ew_in     = R;
        bus.clr_fault = 1'b0;

        // Reset state, including reset overriding a conflicting input.
        step("rst0", 0, R, R, 0, R, R, 0, 2'b00);
        step("rst1", 0, G, G, 0, R, R, 0, 2'b00);

        // Nominal cycle: NS G5/Y3/R then EW G5/Y3/R.
        for (int i = 0; i < 5; i++) step("nom_ns_g", 1, G, R, 0, G, R, 0, 2'b00);
        for (int i = 0; i < 3; i++) step("nom_ns_y", 1, Y, R, 0, Y, R, 0, 2'b00);
        step("nom_ns_r", 1, R, R, 0, R, R, 0, 2'b00);
        for (int i = 0; i < 5; i++) step("nom_ew_g", 1, R, G, 0, R, G, 0, 2'b00);
        for (int i = 0; i < 3; i++) step("nom_ew_y", 1, R, Y, 0, R, Y, 0, 2'b00);
        step("nom_ew_r", 1, R, R, 0, R, R, 0, 2'b00);
        step("nom_ns_g2", 1, G, R, 0, G, R, 0, 2'b00);

        // Single-cycle invalid glitch is masked, no fault.
        step("glitch", 1, 3'b011, R, 0, R, R, 0, 2'b00);
        step("glitch_ok", 1, G, R, 0, G, R, 0, 2'b00);

        // Persistent conflict -> FAULT with code 01.
        step("conf1", 1, G, G, 0, R, R, 0, 2'b00);
        step("conf2", 1, G, G, 0, R, R, 1, 2'b01);
        step("flash1_clr_ign", 1, G, R, 1, R, R, 1, 2'b01);
        step("flash2", 1, R, R, 0, R, R, 1, 2'b01);
        step("flash3", 1, R, R, 0, R, R, 1, 2'b01);
        step("flash4_off", 1, R, R, 0, O, O, 1, 2'b01);
        step("flash5_clr_ign", 1, G, R, 1, O, O, 1, 2'b01);
        step("flash6_off", 1, R, R, 0, O, O, 1, 2'b01);
        step("flash7_off", 1, R, R, 0, O, O, 1, 2'b01);
        step("flash8_wrap", 1, R, R, 0, R, R, 1, 2'b01);
        step("clr_ok", 1, R, R, 1, R, R, 1, 2'b01);

        // Recovery hold restarts on a non-red input; clr ignored in RECOVER.
        step("hold1", 1, R, R, 0, R, R, 1, 2'b01);
        step("hold2_clr", 1, R, R, 1, R, R, 1, 2'b01);
        step("hold_break", 1, G, R, 0, R, R, 1, 2'b01);
        for (int i = 0; i < 3; i++) step("hold_again", 1, R, R, 0, R, R, 1, 2'b01);
        step("hold_done", 1, R, R, 0, R, R, 0, 2'b01);
        step("mon_code_kept", 1, R, R, 0, R, R, 0, 2'b01);

        // Short yellow (2 cycles) -> FAULT code 11.
        step("sy_g", 1, G, R, 0, G, R, 0, 2'b01);
        step("sy_y1", 1, Y, R, 0, Y, R, 0, 2'b01);
        step("sy_y2", 1, Y, R, 0, Y, R, 0, 2'b01);
        step("sy_r", 1, R, R, 0, R, R, 1, 2'b11);
        step("sy_flash", 1, R, R, 0, R, R, 1, 2'b11);

        // Reset in the middle of FAULT.
        step("rst_mid", 0, R, R, 0, R, R, 0, 2'b00);

        // Direct G->R -> FAULT code 11.
        step("gr_g", 1, G, R, 0, G, R, 0, 2'b00);
        step("gr_r", 1, R, R, 0, R, R, 1, 2'b11);
        step("rst_gr", 0, R, R, 0, R, R, 0, 2'b00);

        // Yellow violation coinciding with an invalid EW code: invalid wins.
        step("pri_g", 1, G, R, 0, G, R, 0, 2'b00);
        step("pri_r", 1, R, 3'b011, 0, R, R, 1, 2'b10);
        step("rst_pri", 0, R, R, 0, R, R, 0, 2'b00);

        // Persistent invalid -> FAULT code 10.
        step("inv1", 1, O, R, 0, R, R, 0, 2'b00);
        step("inv2", 1, O, R, 0, R, R, 1, 2'b10);
        step("inv_flash", 1, R, R, 0, R, R, 1, 2'b10);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
